alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port in_valid  input  1  command present.
REQ-005 SHALL have port in_ready  output  1  block accepts command.
REQ-006 SHALL have port op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110/111 illegal.
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port y  output  WIDTH  registered result.
REQ-011 SHALL have ports zf, cf, of, sf  output  1 each  registered flags.
REQ-012 SHALL have port err  output  1  illegal or disabled op.

Function
REQ-013 SHALL implement FSM IDLE, EXEC, MUL, DONE.
REQ-014 IDLE: in_ready=1; on in_valid latch op/a/b; go MUL if op=101 and MUL enabled, else EXEC.
REQ-015 in_ready SHALL be 0 in EXEC, MUL, DONE; commands are not accepted there.
REQ-016 EXEC: one cycle; drive latched op/a/b into the ALU; register y and flags; go DONE. out_valid rises one cycle after the accept edge.
REQ-017 ADD/SUB flags: cf = carry out (ADD) or borrow (SUB); of = signed overflow; zf = (y==0); sf = y[WIDTH-1].
REQ-018 AND/OR/XOR flags: cf=0, of=0; zf and sf computed from y.
REQ-019 MUL: shift-add over WIDTH cycles using the ALU in ADD mode; each cycle, if the multiplier LSB is 1, acc = acc + multiplicand; then multiplicand shifts left 1 and multiplier shifts right 1.
REQ-020 MUL result: y = low WIDTH bits of the product; cf = of = 1 if the true product exceeds WIDTH bits (unsigned); zf and sf from y; out_valid rises WIDTH cycles after the accept edge.
REQ-021 Illegal op: take EXEC timing; y=0; all flags 0; err=1.
REQ-022 DONE: out_valid=1; y, flags and err held stable until out_ready=1; on out_valid&out_ready return to IDLE next cycle.
REQ-023 err SHALL be 0 for every legal completed op.
REQ-024 Operands of 0 SHALL still take the full MUL latency; there is no early termination.

Reset
REQ-025 rst SHALL force IDLE, y=0, zf=cf=of=sf=0, err=0, out_valid=0, in_ready=1 at the next edge, from any state including mid-MUL; a pending result is discarded.
REQ-026 in_valid SHALL be ignored in any cycle where rst=1.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN defined: op 101 executes the MUL path per REQ-019/020.
REQ-028 Macro absent: MUL state and shift registers are not built; op 101 is handled as illegal per REQ-021.

Structure
REQ-029 A shared package cod_pkg SHALL hold the op code constants, the FSM state type and the flag-vector layout.
REQ-030 SHALL instantiate the existing combinational ALU as its one sub-module, alu (WIDTH passed through), shared between EXEC and MUL with its operand/op inputs muxed by state.

Verification
REQ-031 ADD a=0x7FFFFFFF, b=1 -> y=0x80000000, of=1, cf=0, sf=1, zf=0, out_valid 1 cycle after accept.
REQ-032 SUB a=3, b=5 -> y=0xFFFFFFFE, cf=1, sf=1, of=0; SUB a=5, b=5 -> y=0, zf=1, cf=0.
REQ-033 MUL a=0x00010000, b=0x00010000 -> y=0, cf=1, of=1, zf=1, out_valid 32 cycles after accept; MUL 7*6 -> y=42, cf=0.
REQ-034 out_ready held 0 for 5 cycles after out_valid -> y, flags and out_valid are stable; in_ready stays 0 until the handshake.
REQ-035 rst asserted in MUL cycle 10 -> next cycle IDLE, all outputs 0, in_ready=1; a following ADD 2+2 -> y=4.
REQ-036 op=111 -> y=0, err=1, flags 0; without ALU_SEQ_MUL_EN, op=101 -> err=1.

Source files
------------

// File: rtl/cod_pkg.sv
// Shared definitions for the sequential ALU: op codes, controller states and flag layout.
package cod_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic zf;
        logic cf;
        logic of;
        logic sf;
    } flags_t;

    // True for the single-cycle ops the combinational ALU evaluates.
    function automatic logic op_is_alu(input logic [2:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR with flags; any other op yields zero result and flags.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output cod_pkg::flags_t  flags_o
);
    import cod_pkg::*;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] res_s;
    logic             cf_s;
    logic             of_s;

    assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_s = {1'b0, a_i} - {1'b0, b_i};

    // Result and arithmetic flags per op; the top bit of diff_s is the borrow.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        cf_s  = 1'b0;
        of_s  = 1'b0;
        case (op_i)
            OP_ADD: begin
                res_s = sum_s[WIDTH-1:0];
                cf_s  = sum_s[WIDTH];
                of_s  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                res_s = diff_s[WIDTH-1:0];
                cf_s  = diff_s[WIDTH];
                of_s  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  res_s = a_i & b_i;
            OP_OR:   res_s = a_i | b_i;
            OP_XOR:  res_s = a_i ^ b_i;
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // Zero/sign only reported for ops the ALU actually evaluates.
    always_comb begin
        y_o        = res_s;
        flags_o.cf = cf_s;
        flags_o.of = of_s;
        if (op_is_alu(op_i)) begin
            flags_o.zf = (res_s == {WIDTH{1'b0}});
            flags_o.sf = res_s[WIDTH-1];
        end else begin
            flags_o.zf = 1'b0;
            flags_o.sf = 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes around a shared combinational ALU.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier; otherwise op 101 is illegal.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zf,
    output logic             cf,
    output logic             of,
    output logic             sf,
    output logic             err
);
    import cod_pkg::*;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    flags_t           flags_q, flags_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [2:0]       alu_op_s;
    logic [WIDTH-1:0] alu_a_s;
    logic [WIDTH-1:0] alu_b_s;
    logic [WIDTH-1:0] alu_y_s;
    flags_t           alu_flags_s;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lost_q, lost_d;
    logic             ovf_q, ovf_d;
`endif

    alu #(.WIDTH(WIDTH)) u_alu (
        .op_i    (alu_op_s),
        .a_i     (alu_a_s),
        .b_i     (alu_b_s),
        .y_o     (alu_y_s),
        .flags_o (alu_flags_s)
    );

    // ALU operand mux: multiplier steps add the multiplicand into the accumulator.
    always_comb begin
        alu_op_s = op_q;
        alu_a_s  = a_q;
        alu_b_s  = b_q;
`ifdef ALU_SEQ_MUL_EN
        if (state_q == ST_MUL) begin
            alu_op_s = OP_ADD;
            alu_a_s  = acc_q;
            alu_b_s  = a_q;
        end else begin
            alu_op_s = op_q;
        end
`endif
    end

    // Controller next state and datapath updates.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        y_d         = y_q;
        flags_d     = flags_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        lost_d      = lost_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d       = op;
                    a_d        = a;
                    b_d        = b;
                    in_ready_d = 1'b0;
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        state_d = ST_MUL;
                        acc_d   = {WIDTH{1'b0}};
                        cnt_d   = {CW{1'b0}};
                        lost_d  = 1'b0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_EXEC;
                    end
`else
                    state_d = ST_EXEC;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                y_d         = alu_y_s;
                flags_d     = alu_flags_s;
                err_d       = !op_is_alu(op_q);
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                // Overflow once a set multiplier bit meets a multiplicand that has lost
                // high bits, or the truncated accumulation carries out.
                if (b_q[0]) begin
                    acc_d = alu_y_s;
                    ovf_d = ovf_q | lost_q | alu_flags_s.cf;
                end else begin
                    acc_d = acc_q;
                end
                lost_d = lost_q | a_q[WIDTH-1];
                a_d    = {a_q[WIDTH-2:0], 1'b0};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    y_d         = acc_d;
                    flags_d.zf  = (acc_d == {WIDTH{1'b0}});
                    flags_d.sf  = acc_d[WIDTH-1];
                    flags_d.cf  = ovf_d;
                    flags_d.of  = ovf_d;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Controller and result registers; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'b000;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            y_q         <= {WIDTH{1'b0}};
            flags_q     <= 4'b0000;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    // Multiplier accumulator, step counter and overflow tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= {WIDTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
            lost_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            lost_q <= lost_d;
            ovf_q  <= ovf_d;
        end
    end
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zf        = flags_q.zf;
    assign cf        = flags_q.cf;
    assign of        = flags_q.of;
    assign sf        = flags_q.sf;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; MUL vectors apply when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] y;
    logic         zf, cf, of, sf, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zf        (zf),
        .cf        (cf),
        .of        (of),
        .sf        (sf),
        .err       (err)
    );

    // Present one command, then count cycles after the accept edge until out_valid (bounded).
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z, output int cyc);
        op = o; a = x; b = z; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; op = 3'b000; a = 32'd1; b = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h want 0", y); end
        checks++; if ({zf, cf, of, sf, err} !== 5'b00000) begin errors++; $display("FAIL reset_flags got %b want 00000", {zf, cf, of, sf, err}); end
        rst = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL reset_ignores_valid got %b want 10", {in_ready, out_valid}); end
    endtask

    task automatic test_add_sub();
        logic [2:0]   t_op [5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001};
        logic [W-1:0] t_a  [5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd5, 32'h8000_0000};
        logic [W-1:0] t_b  [5] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd1};
        logic [W-1:0] t_y  [5] = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h7FFF_FFFF};
        logic [3:0]   t_f  [5] = '{4'b0011, 4'b1100, 4'b0101, 4'b1000, 4'b0010};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(t_op[i], t_a[i], t_b[i], lat);
            checks++; if (lat !== 1) begin errors++; $display("FAIL arith_latency[%0d] got %0d want 1", i, lat); end
            checks++; if (y !== t_y[i]) begin errors++; $display("FAIL arith_y[%0d] got %h want %h", i, y, t_y[i]); end
            checks++; if ({zf, cf, of, sf} !== t_f[i]) begin errors++; $display("FAIL arith_flags[%0d] zcos got %b want %b", i, {zf, cf, of, sf}, t_f[i]); end
            checks++; if ({err, in_ready} !== 2'b00) begin errors++; $display("FAIL arith_err_ready[%0d] got %b want 00", i, {err, in_ready}); end
            handshake();
            checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL arith_handshake[%0d] got %b want 10", i, {in_ready, out_valid}); end
        end
    endtask

    task automatic test_logic_illegal();
        logic [2:0]   t_op [5] = '{3'b010, 3'b011, 3'b111, 3'b100, 3'b110};
        logic [W-1:0] t_a  [5] = '{32'hF0F0_F0F0, 32'h0000_00F0, 32'h1234_5678, 32'hA5A5_A5A5, 32'hFFFF_FFFF};
        logic [W-1:0] t_b  [5] = '{32'hFF00_FF00, 32'h0000_000F, 32'h1111_1111, 32'hA5A5_A5A5, 32'd1};
        logic [W-1:0] t_y  [5] = '{32'hF000_F000, 32'h0000_00FF, 32'h0, 32'h0, 32'h0};
        logic [3:0]   t_f  [5] = '{4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        logic         t_e  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(t_op[i], t_a[i], t_b[i], lat);
            checks++; if (lat !== 1) begin errors++; $display("FAIL logic_latency[%0d] got %0d want 1", i, lat); end
            checks++; if (y !== t_y[i]) begin errors++; $display("FAIL logic_y[%0d] got %h want %h", i, y, t_y[i]); end
            checks++; if ({zf, cf, of, sf} !== t_f[i]) begin errors++; $display("FAIL logic_flags[%0d] got %b want %b", i, {zf, cf, of, sf}, t_f[i]); end
            checks++; if (err !== t_e[i]) begin errors++; $display("FAIL logic_err[%0d] got %b want %b", i, err, t_e[i]); end
            handshake();
        end
    endtask

    task automatic test_mul();
        int lat;
`ifdef ALU_SEQ_MUL_EN
        logic [W-1:0] t_a [5] = '{32'h0001_0000, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd2};
        logic [W-1:0] t_b [5] = '{32'h0001_0000, 32'd6, 32'd0, 32'd1, 32'h8000_0000};
        logic [W-1:0] t_y [5] = '{32'h0, 32'd42, 32'h0, 32'hFFFF_FFFF, 32'h0};
        logic [3:0]   t_f [5] = '{4'b1110, 4'b0000, 4'b1000, 4'b0001, 4'b1110};
        for (int i = 0; i < 5; i++) begin
            issue(3'b101, t_a[i], t_b[i], lat);
            checks++; if (lat !== W) begin errors++; $display("FAIL mul_latency[%0d] got %0d want %0d", i, lat, W); end
            checks++; if (y !== t_y[i]) begin errors++; $display("FAIL mul_y[%0d] got %h want %h", i, y, t_y[i]); end
            checks++; if ({zf, cf, of, sf} !== t_f[i]) begin errors++; $display("FAIL mul_flags[%0d] got %b want %b", i, {zf, cf, of, sf}, t_f[i]); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL mul_err[%0d] got %b want 0", i, err); end
            handshake();
        end
`else
        issue(3'b101, 32'd7, 32'd6, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL mul_disabled_latency got %0d want 1", lat); end
        checks++; if ({y, zf, cf, of, sf, err} !== {32'h0, 5'b00001}) begin errors++; $display("FAIL mul_disabled_result got %h/%b want 0/00001", y, {zf, cf, of, sf, err}); end
        handshake();
`endif
    endtask

    task automatic test_stall();
        int lat;
        issue(3'b000, 32'd10, 32'd20, lat);
        checks++; if (lat !== 1 || y !== 32'd30) begin errors++; $display("FAIL stall_result got %0d/%h want 1/0000001e", lat, y); end
        in_valid = 1'b1; op = 3'b001; a = 32'd100; b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, y, zf, cf, of, sf, err} !== {2'b10, 32'd30, 5'b00000}) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v%b r%b y%h f%b want v1 r0 y0000001e f00000", i, out_valid, in_ready, y, {zf, cf, of, sf, err});
            end
        end
        in_valid = 1'b0;
        handshake();
        checks++; if ({in_ready, out_valid, y} !== {2'b10, 32'd30}) begin errors++; $display("FAIL stall_release got %b/%h want 10/0000001e", {in_ready, out_valid}, y); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
`ifdef ALU_SEQ_MUL_EN
        op = 3'b101; a = 32'd3; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
`else
        issue(3'b000, 32'd2, 32'd3, lat);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, y, zf, cf, of, sf, err} !== {2'b10, 32'h0, 5'b00000}) begin
            errors++;
            $display("FAIL midrst_state got r%b v%b y%h f%b want r1 v0 y0 f00000", in_ready, out_valid, y, {zf, cf, of, sf, err});
        end
        repeat (40) @(posedge clk);
        #1;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL midrst_discard got %b want 10", {in_ready, out_valid}); end
        issue(3'b000, 32'd2, 32'd2, lat);
        checks++; if (lat !== 1 || y !== 32'd4) begin errors++; $display("FAIL midrst_add got %0d/%h want 1/00000004", lat, y); end
        handshake();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'b000; a = '0; b = '0;
        test_reset();
        test_add_sub();
        test_logic_illegal();
        test_mul();
        test_stall();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
